shift_op_sequencer: RTL and testbench



---
 rtl/shift_op_sequencer.sv | 151 +++++++++++++++
 tb/tb_shift_op_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_op_sequencer.sv
// Multi-op shift unit: sequences one or two passes through a single 8-bit
// combinational barrel shifter to provide SLL, SRL, ROL and SRA.

module Barrel_Shifter (
  input  logic [7:0] data,
  input  logic [2:0] shift,
  input  logic       LR,
  output logic [7:0] out
);
  // LR=0 shifts left, LR=1 shifts right; both fill with zeros.
  assign out = LR ? (data >> shift) : (data << shift);
endmodule

module shift_op_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic [1:0] op,
  input  logic [7:0] din,
  input  logic [2:0] amt,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       busy,
  output logic [7:0] ops_done
);

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_ROL = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  din_q, din_d;
  logic [2:0]  amt_q, amt_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  dout_q, dout_d;
  logic        dout_valid_q, dout_valid_d;
  logic [7:0]  ops_done_q, ops_done_d;

  logic [7:0]  sh_data;
  logic [2:0]  sh_amt;
  logic        sh_lr;
  logic [7:0]  sh_out;

  Barrel_Shifter u_shifter (
    .data  (sh_data),
    .shift (sh_amt),
    .LR    (sh_lr),
    .out   (sh_out)
  );

  assign start_ready = (state_q == IDLE) && !rst;
  assign busy        = (state_q != IDLE);
  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign ops_done    = ops_done_q;

  // NOTE: every signal gets a default before the case so no path leaves a latch.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    din_d        = din_q;
    amt_d        = amt_q;
    acc_d        = acc_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    ops_done_d   = ops_done_q;
    sh_data      = din_q;
    sh_amt       = amt_q;
    sh_lr        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_valid && start_ready) begin
          op_d    = op;
          din_d   = din;
          amt_d   = amt;
          state_d = PASS1;
        end
      end

      PASS1: begin
        sh_lr = (op_q == OP_SRL) || (op_q == OP_SRA);
        acc_d = sh_out;
        if ((op_q == OP_SLL) || (op_q == OP_SRL)) begin
          state_d = DONE;
        end else if (amt_q == 3'd0) begin
          acc_d   = din_q;
          state_d = DONE;
        end else begin
          state_d = PASS2;
        end
      end

      PASS2: begin
        sh_lr = 1'b1;
        if (op_q == OP_ROL) begin
          // 8-amt wraps into 3 bits correctly since amt is nonzero here.
          sh_amt = 3'd0 - amt_q;
          acc_d  = acc_q | sh_out;
        end else begin
          sh_data = 8'hFF;
          acc_d   = acc_q | (din_q[7] ? ~sh_out : 8'h00);
        end
        state_d = DONE;
      end

      DONE: begin
        if (!dout_valid_q) begin
          dout_d       = acc_q;
          dout_valid_d = 1'b1;
        end else if (dout_ready) begin
          dout_valid_d = 1'b0;
          ops_done_d   = ops_done_q + 8'd1;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= 2'b00;
      din_q        <= 8'h00;
      amt_q        <= 3'd0;
      acc_q        <= 8'h00;
      dout_q       <= 8'h00;
      dout_valid_q <= 1'b0;
      ops_done_q   <= 8'h00;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      din_q        <= din_d;
      amt_q        <= amt_d;
      acc_q        <= acc_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      ops_done_q   <= ops_done_d;
    end
  end

endmodule

// File: tb/tb_shift_op_sequencer.sv
// Directed self-checking bench for shift_op_sequencer: per-op results and
// latency, backpressure, mid-operation reset and ops_done wrap.

module tb_shift_op_sequencer;

  logic       clk;
  logic       rst;
  logic       start_valid;
  logic       start_ready;
  logic [1:0] op;
  logic [7:0] din;
  logic [2:0] amt;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       busy;
  logic [7:0] ops_done;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_ops = 8'h00;

  shift_op_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op          (op),
    .din         (din),
    .amt         (amt),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .busy        (busy),
    .ops_done    (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_model(input logic [1:0] o, input logic [7:0] d,
                                           input logic [2:0] a);
    logic [7:0] r;
    case (o)
      2'b00: r = d << a;
      2'b01: r = d >> a;
      2'b10: r = (a == 3'd0) ? d : ((d << a) | (d >> (4'd8 - {1'b0, a})));
      default: r = 8'($signed(d) >>> a);
    endcase
    return r;
  endfunction

  // Present a request for one edge; inputs are scrambled right after accept.
  task automatic issue(input logic [1:0] o, input logic [7:0] d, input logic [2:0] a);
    op          = o;
    din         = d;
    amt         = a;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    op          = ~o;
    din         = ~d;
    amt         = ~a;
  endtask

  task automatic wait_result(input string tag, input logic [7:0] exp, input int lat);
    int n = 0;
    while (!dout_valid && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, lat);
    check({tag, "_dout"}, dout, exp);
  endtask

  task automatic handshake(input string tag, input logic [7:0] exp);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    exp_ops    = exp_ops + 8'd1;
    check({tag, "_ops"}, ops_done, exp_ops);
    check({tag, "_vld_clr"}, dout_valid, 1'b0);
    check({tag, "_hold"}, dout, exp);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [7:0] d,
                        input logic [2:0] a, input logic [7:0] exp, input int lat);
    issue(o, d, a);
    wait_result(tag, exp, lat);
    handshake(tag, exp);
  endtask

  initial begin
    rst         = 1'b1;
    start_valid = 1'b0;
    op          = 2'b00;
    din         = 8'h00;
    amt         = 3'd0;
    dout_ready  = 1'b0;
    tick();
    tick();

    check("rst_ready", start_ready, 1'b0);
    check("rst_dout",  dout,        8'h00);
    check("rst_valid", dout_valid,  1'b0);
    check("rst_busy",  busy,        1'b0);
    check("rst_ops",   ops_done,    8'h00);

    rst = 1'b0;
    #1;
    check("post_rst_ready", start_ready, 1'b1);

    run_op("sll_b3_3",  2'b00, 8'hB3, 3'd3, 8'h98, 2);
    run_op("rol_b3_3",  2'b10, 8'hB3, 3'd3, 8'h9D, 3);
    run_op("rol_b3_0",  2'b10, 8'hB3, 3'd0, 8'hB3, 2);
    run_op("sra_b3_2",  2'b11, 8'hB3, 3'd2, 8'hEC, 3);
    run_op("sra_73_2",  2'b11, 8'h73, 3'd2, 8'h1C, 3);
    run_op("sra_80_7",  2'b11, 8'h80, 3'd7, 8'hFF, 3);
    run_op("srl_80_7",  2'b01, 8'h80, 3'd7, 8'h01, 2);
    run_op("sra_b3_0",  2'b11, 8'hB3, 3'd0, 8'hB3, 2);

    // Backpressure with spurious start pulses while DONE.
    issue(2'b01, 8'hC4, 3'd2);
    wait_result("bp", 8'h31, 2);
    for (int i = 0; i < 5; i++) begin
      start_valid = 1'b1;
      op          = 2'b00;
      din         = 8'h5A;
      amt         = 3'd1;
      tick();
      start_valid = 1'b0;
      check("bp_dout",  dout,        8'h31);
      check("bp_valid", dout_valid,  1'b1);
      check("bp_ready", start_ready, 1'b0);
      check("bp_busy",  busy,        1'b1);
      check("bp_ops",   ops_done,    exp_ops);
    end
    handshake("bp", 8'h31);
    tick();
    check("bp_no_capture", busy, 1'b0);

    // Reset while a ROL sits in PASS2.
    issue(2'b10, 8'hB3, 3'd3);
    tick();
    check("mid_busy", busy, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_dout",  dout,        8'h00);
    check("mid_rst_valid", dout_valid,  1'b0);
    check("mid_rst_busy",  busy,        1'b0);
    check("mid_rst_ops",   ops_done,    8'h00);
    check("mid_rst_ready", start_ready, 1'b0);
    @(posedge clk);
    #1 rst  = 1'b0;
    exp_ops = 8'h00;
    run_op("srl_f0_4", 2'b01, 8'hF0, 3'd4, 8'h0F, 2);

    // 256 back-to-back SLL ops from a clean reset: ops_done must wrap to 0.
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    exp_ops = 8'h00;
    check("wrap_start", ops_done, 8'h00);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] d;
      logic [2:0] a;
      d = 8'($urandom);
      a = 3'($urandom_range(7));
      run_op("rand_sll", 2'b00, d, a, ref_model(2'b00, d, a), 2);
    end
    check("wrap_zero", ops_done, 8'h00);

    // A few random ops across all opcodes against the model.
    for (int i = 0; i < 16; i++) begin
      logic [1:0] o;
      logic [7:0] d;
      logic [2:0] a;
      o = 2'($urandom);
      d = 8'($urandom);
      a = 3'($urandom_range(7));
      run_op("rand_any", o, d, a, ref_model(o, d, a),
             ((o[1] == 1'b1) && (a != 3'd0)) ? 3 : 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
